// File: rtl/arb_seq_checker.sv
// Receive-side lock/violation checker for the 3,0,1,5,2,7,6,4,9,12 counter stream; `ARB_SEQ_CHK_RESYNC_EN reseeds ACQ on a legal locked mismatch.
// Latency: every output is registered and updates on the posedge that samples in_valid=1.
// Backpressure: none; in_valid=0 holds all state and masks the error pulses.
module arb_seq_checker #(
    parameter int LOCK_CNT = 3,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [3:0]    in_code,
    input  logic          wrap_in,
    output logic [3:0]    index,
    output logic          code_ok,
    output logic          locked,
    output logic          seq_err,
    output logic          wrap_err,
    output logic [CW-1:0] cycle_cnt,
    output logic [CW-1:0] err_cnt
);
    localparam logic [3:0] NO_IDX   = 4'hF;
    localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);

    typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

    state_t     state, state_nxt;
    logic [3:0] prev, prev_nxt;
    logic [3:0] run, run_nxt;
    logic [3:0] idx, succ;
    logic       legal, is_succ;
    logic       seq_err_nxt, wrap_err_nxt, cyc_inc, err_inc;

    always_comb begin
        idx = NO_IDX;
        case (in_code)
            4'd3:    idx = 4'd0;
            4'd0:    idx = 4'd1;
            4'd1:    idx = 4'd2;
            4'd5:    idx = 4'd3;
            4'd2:    idx = 4'd4;
            4'd7:    idx = 4'd5;
            4'd6:    idx = 4'd6;
            4'd4:    idx = 4'd7;
            4'd9:    idx = 4'd8;
            4'd12:   idx = 4'd9;
            default: idx = NO_IDX;
        endcase
    end

    assign legal   = (idx != NO_IDX);
    assign succ    = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
    // prev=F must never match ordinal 0 through the +1 wrap.
    assign is_succ = legal && (prev != NO_IDX) && (idx == succ);

    always_comb begin
        state_nxt    = state;
        prev_nxt     = prev;
        run_nxt      = run;
        seq_err_nxt  = 1'b0;
        wrap_err_nxt = 1'b0;
        cyc_inc      = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (legal) begin
                        state_nxt = ACQ;
                        prev_nxt  = idx;
                        run_nxt   = 4'd0;
                    end
                end
                ACQ: begin
                    if (is_succ) begin
                        prev_nxt = idx;
                        run_nxt  = run + 4'd1;
                        if (run + 4'd1 == LOCK_RUN)
                            state_nxt = LOCKED;
                    end else if (legal) begin
                        prev_nxt = idx;
                        run_nxt  = 4'd0;
                    end else begin
                        state_nxt = HUNT;
                        prev_nxt  = NO_IDX;
                        run_nxt   = 4'd0;
                    end
                end
                LOCKED: begin
                    if (is_succ) begin
                        prev_nxt     = idx;
                        cyc_inc      = (prev == 4'd9);
                        wrap_err_nxt = (wrap_in != (prev == 4'd9));
                    end else begin
                        seq_err_nxt = 1'b1;
                        run_nxt     = 4'd0;
`ifdef ARB_SEQ_CHK_RESYNC_EN
                        if (legal) begin
                            state_nxt = ACQ;
                            prev_nxt  = idx;
                        end else begin
                            state_nxt = HUNT;
                            prev_nxt  = NO_IDX;
                        end
`else
                        state_nxt = HUNT;
                        prev_nxt  = NO_IDX;
`endif
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    prev_nxt  = NO_IDX;
                    run_nxt   = 4'd0;
                end
            endcase
        end
    end

    assign err_inc = seq_err_nxt | wrap_err_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            prev      <= NO_IDX;
            run       <= 4'd0;
            index     <= NO_IDX;
            code_ok   <= 1'b0;
            seq_err   <= 1'b0;
            wrap_err  <= 1'b0;
            cycle_cnt <= '0;
            err_cnt   <= '0;
        end else if (clear) begin
            state     <= HUNT;
            prev      <= NO_IDX;
            run       <= 4'd0;
            index     <= NO_IDX;
            code_ok   <= 1'b0;
            seq_err   <= 1'b0;
            wrap_err  <= 1'b0;
            cycle_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            prev     <= prev_nxt;
            run      <= run_nxt;
            seq_err  <= seq_err_nxt;
            wrap_err <= wrap_err_nxt;
            if (in_valid) begin
                index   <= idx;
                code_ok <= legal;
            end
            if (cyc_inc)
                cycle_cnt <= cycle_cnt + CW'(1);
            if (err_inc && (err_cnt != '1))
                err_cnt <= err_cnt + CW'(1);
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_arb_seq_checker.sv
// Bench for arb_seq_checker: directed scenarios plus randomized streams against a sequence-level reference model.
module tb_arb_seq_checker;
    localparam int LOCK_CNT = 3;
    localparam int CW       = 8;

    logic          clk = 1'b0;
    logic          reset, clear, in_valid, wrap_in;
    logic [3:0]    in_code;
    logic [3:0]    index;
    logic          code_ok, locked, seq_err, wrap_err;
    logic [CW-1:0] cycle_cnt, err_cnt;

    arb_seq_checker #(.LOCK_CNT(LOCK_CNT), .CW(CW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_code(in_code), .wrap_in(wrap_in), .index(index), .code_ok(code_ok),
        .locked(locked), .seq_err(seq_err), .wrap_err(wrap_err),
        .cycle_cnt(cycle_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int seq_codes[10] = '{3, 0, 1, 5, 2, 7, 6, 4, 9, 12};

    // Reference model: mode 0=hunting, 1=acquiring, 2=locked; prev=15 means no history.
    int m_mode, m_prev, m_run, m_index, m_ok, m_seq, m_wrap, m_cyc, m_err;
    int tx_pos;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ord_of(input int c);
        for (int i = 0; i < 10; i++)
            if (seq_codes[i] == c) return i;
        return 15;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_prev = 15; m_run = 0; m_index = 15; m_ok = 0;
        m_seq = 0; m_wrap = 0; m_cyc = 0; m_err = 0;
    endtask

    task automatic bump_err();
        if (m_err < (1 << CW) - 1) m_err++;
    endtask

    task automatic model_step(input bit v, input int c, input bit w, input bit clr);
        int  idx, old;
        bit  ok, nxt;
        if (clr) begin
            model_reset();
            return;
        end
        m_seq = 0;
        m_wrap = 0;
        if (!v) return;
        idx = ord_of(c);
        ok = (idx != 15);
        m_index = idx;
        m_ok = ok;
        nxt = ok && (m_prev != 15) && (idx == (m_prev + 1) % 10);
        old = m_prev;
        if (m_mode == 0) begin
            if (ok) begin m_mode = 1; m_prev = idx; m_run = 0; end
        end else if (m_mode == 1) begin
            if (nxt) begin
                m_prev = idx;
                m_run++;
                if (m_run == LOCK_CNT) m_mode = 2;
            end else if (ok) begin
                m_prev = idx; m_run = 0;
            end else begin
                m_mode = 0; m_prev = 15; m_run = 0;
            end
        end else begin
            if (nxt) begin
                m_prev = idx;
                if (w != (old == 9)) begin m_wrap = 1; bump_err(); end
                if (old == 9) m_cyc = (m_cyc + 1) % (1 << CW);
            end else begin
                m_seq = 1;
                bump_err();
                m_run = 0;
`ifdef ARB_SEQ_CHK_RESYNC_EN
                if (ok) begin m_mode = 1; m_prev = idx; end
                else    begin m_mode = 0; m_prev = 15; end
`else
                m_mode = 0; m_prev = 15;
`endif
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".index"},    32'(index),     32'(m_index));
        check({tag, ".code_ok"},  32'(code_ok),   32'(m_ok));
        check({tag, ".locked"},   32'(locked),    32'(m_mode == 2));
        check({tag, ".seq_err"},  32'(seq_err),   32'(m_seq));
        check({tag, ".wrap_err"}, 32'(wrap_err),  32'(m_wrap));
        check({tag, ".cycle"},    32'(cycle_cnt), 32'(m_cyc));
        check({tag, ".err"},      32'(err_cnt),   32'(m_err));
    endtask

    // Called at a negedge: drive, let the posedge sample, then compare 1ns later.
    task automatic step(input bit v, input int c, input bit w, input bit clr, input string tag);
        in_valid = v;
        in_code  = 4'(c);
        wrap_in  = w;
        clear    = clr;
        @(posedge clk);
        model_step(v, c, w, clr);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic feed(input int c, input bit w, input string tag);
        step(1'b1, c, w, 1'b0, tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".index"},   32'(index),     32'd15);
        check({tag, ".code_ok"}, 32'(code_ok),   32'd0);
        check({tag, ".locked"},  32'(locked),    32'd0);
        check({tag, ".seq_err"}, 32'(seq_err),   32'd0);
        check({tag, ".wrap_err"},32'(wrap_err),  32'd0);
        check({tag, ".cycle"},   32'(cycle_cnt), 32'd0);
        check({tag, ".err"},     32'(err_cnt),   32'd0);
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_code = 4'd0; wrap_in = 1'b0;
        model_reset();
        #12;
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b1;

        // Illegal code while hunting.
        feed(15, 0, "illegal");
        check("illegal.err_const", 32'(err_cnt), 32'd0);

        // Acquire lock.
        feed(3, 0, "acq3"); feed(0, 0, "acq0"); feed(1, 0, "acq1"); feed(5, 0, "acq5");
        check("lock.locked_const", 32'(locked), 32'd1);
        check("lock.index_const",  32'(index),  32'd3);

        // Full cycle with idle gaps, correct wrap.
        feed(2, 0, "c2");
        step(1'b0, 9, 1, 1'b0, "gap1");
        feed(7, 0, "c7"); feed(6, 0, "c6"); feed(4, 0, "c4"); feed(9, 0, "c9");
        step(1'b0, 0, 0, 1'b0, "gap2");
        feed(12, 0, "c12");
        feed(3, 1, "wrap_ok");
        check("wrap_ok.cycle_const", 32'(cycle_cnt), 32'd1);
        check("wrap_ok.err_const",    32'(err_cnt),   32'd0);
        check("wrap_ok.index_const", 32'(index),     32'd0);

        // Sequence error while locked at 7.
        feed(0, 0, "s0"); feed(1, 0, "s1"); feed(5, 0, "s5"); feed(2, 0, "s2"); feed(7, 0, "s7");
        feed(4, 0, "seqerr");
        check("seqerr.pulse_const",  32'(seq_err), 32'd1);
        check("seqerr.err_const",    32'(err_cnt), 32'd1);
        check("seqerr.locked_const", 32'(locked),  32'd0);
`ifdef ARB_SEQ_CHK_RESYNC_EN
        feed(9, 0, "resync9");
`else
        feed(6, 0, "hunt6");
`endif
        check("seqerr.pulse_off", 32'(seq_err), 32'd0);
        for (int i = 0; i < 12 && m_mode != 2; i++) feed(seq_codes[(m_prev + 1) % 10], 0, "relock");
        check("relock.locked_const", 32'(locked), 32'd1);

        // Wrap error at 12 -> 3.
        for (int i = 0; i < 10 && m_prev != 9; i++) feed(seq_codes[(m_prev + 1) % 10], 0, "to12");
        feed(3, 0, "wraperr");
        check("wraperr.pulse_const",  32'(wrap_err),  32'd1);
        check("wraperr.err_const",    32'(err_cnt),   32'd2);
        check("wraperr.locked_const", 32'(locked),    32'd1);
        check("wraperr.cycle_const",  32'(cycle_cnt), 32'd2);
        feed(0, 0, "wraperr_after");

        // Synchronous clear with a valid sample.
        step(1'b1, 1, 0, 1'b1, "clear");
        check_reset_values("clear_c");

        // Async reset mid-acquisition.
        feed(3, 0, "racq3"); feed(0, 0, "racq0");
        in_valid = 1'b1; in_code = 4'd1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_rst");
        @(negedge clk);
        reset = 1'b1;

        // Randomized stream with injected faults.
        tx_pos = 0;
        for (int n = 0; n < 3000; n++) begin
            bit v, w, clr;
            int c, r;
            v   = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 299) == 0);
            r   = $urandom_range(0, 31);
            if (r == 2) tx_pos = (tx_pos + 1) % 10;
            c = seq_codes[tx_pos];
            w = (tx_pos == 0);
            if (r == 0) c = $urandom_range(0, 15);
            if (r == 1) w = ~w;
            step(v, c, w, clr, "rand");
            if (v && !clr) tx_pos = (tx_pos + 1) % 10;
        end

        // err_cnt saturation: wrap flag held high while locked.
        step(1'b0, 0, 0, 1'b1, "sat_clr");
        tx_pos = 0;
        for (int n = 0; n < 300; n++) begin
            feed(seq_codes[tx_pos], 1, "sat");
            tx_pos = (tx_pos + 1) % 10;
        end
        check("sat.err_const", 32'(err_cnt), 32'd255);

        // cycle_cnt modulo wrap on a clean stream.
        step(1'b0, 0, 0, 1'b1, "cyc_clr");
        tx_pos = 0;
        for (int n = 0; n < 2600; n++) begin
            feed(seq_codes[tx_pos], (tx_pos == 0 && n > 0), "cyc");
            tx_pos = (tx_pos + 1) % 10;
        end
        check("cyc.wrap_const", 32'(cycle_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
